// File: rtl/boot_rom_pkg.sv
// Shared types and helpers for the boot ROM request adapter.
//   rom_rsp_t             : one response beat (read data + error flag)
//   ROM_RSP_DEPTH_DEFAULT : default response FIFO depth
//   is_word_aligned()     : true when a byte address selects a whole ROM word

`ifndef ROM_ADDR_WIDTH
`define ROM_ADDR_WIDTH 12
`endif

package boot_rom_pkg;

    localparam int unsigned ROM_DATA_WIDTH        = 32;
    localparam int unsigned ROM_RSP_DEPTH_DEFAULT = 2;

    typedef struct packed {
        logic [ROM_DATA_WIDTH-1:0] data;
        logic                      err;
    } rom_rsp_t;

    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return addr_lsb == 2'b00;
    endfunction

endpackage

// File: rtl/boot_rom_rsp_fifo.sv
// Synchronous FIFO of rom_rsp_t responses.
// Ports:
//   clk_i, rst_i       : clock, synchronous active-high reset
//   push_i, wdata_i    : write one entry at the tail
//   pop_i, rdata_o     : rdata_o is the head entry, removed on pop_i
//   full_o, empty_o    : occupancy flags
//   count_o            : number of stored entries

module boot_rom_rsp_fifo
    import boot_rom_pkg::*;
#(
    parameter int unsigned Depth = ROM_RSP_DEPTH_DEFAULT,
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  rom_rsp_t        wdata_i,
    input  logic            pop_i,
    output rom_rsp_t        rdata_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [CntW-1:0] count_o
);

    rom_rsp_t        mem_q [Depth];
    logic [PtrW-1:0] wptr_q;
    logic [PtrW-1:0] rptr_q;
    logic [CntW-1:0] count_q;
    logic            push_en;
    logic            pop_en;

    // Pointers wrap modulo Depth, which need not be a power of two.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
    endfunction

    always_comb begin
        full_o  = (count_q == CntW'(Depth));
        empty_o = (count_q == '0);
        push_en = push_i && (!full_o || pop_i);
        pop_en  = pop_i && !empty_o;
        rdata_o = mem_q[rptr_q];
        count_o = count_q;
    end

    always_ff @(posedge clk_i) begin
        if (push_en) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_en) begin
                wptr_q <= ptr_inc(wptr_q);
            end
            if (pop_en) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            if (push_en && !pop_en) begin
                count_q <= count_q + 1'b1;
            end else if (!push_en && pop_en) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/boot_rom_req_adapter.sv
// Bus-side front end for the boot ROM macro wrapper.
// Accepts single-beat req/gnt requests, drives the ROM enable/address, captures the read
// data one cycle later and returns it through a fall-through response FIFO.
// Writes and misaligned accesses get an error response without enabling the ROM.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   req_i/gnt_o              : request handshake; accepted when both high
//   addr_i, we_i, be_i, wdata_i : request fields (be_i/wdata_i unused, ROM is read-only)
//   rvalid_o/rready_i        : response handshake
//   rdata_o, rerr_o          : response payload (rdata_o is 0 on error)
//   rom_en_o, rom_addr_o     : ROM macro enable and byte address
//   rom_rdata_i              : ROM data, valid the cycle after rom_en_o

`ifndef ROM_ADDR_WIDTH
`define ROM_ADDR_WIDTH 12
`endif

module boot_rom_req_adapter
    import boot_rom_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = `ROM_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = ROM_DATA_WIDTH,
    parameter int unsigned BUS_ADDR_WIDTH = 32,
    parameter int unsigned RSP_DEPTH      = ROM_RSP_DEPTH_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_i,
    output logic                      gnt_o,
    input  logic [BUS_ADDR_WIDTH-1:0] addr_i,
    input  logic                      we_i,
    input  logic [DATA_WIDTH/8-1:0]   be_i,
    input  logic [DATA_WIDTH-1:0]     wdata_i,
    output logic                      rvalid_o,
    input  logic                      rready_i,
    output logic [DATA_WIDTH-1:0]     rdata_o,
    output logic                      rerr_o,
    output logic                      rom_en_o,
    output logic [ADDR_WIDTH-1:0]     rom_addr_o,
    input  logic [DATA_WIDTH-1:0]     rom_rdata_i
);

    localparam int unsigned CntW = $clog2(RSP_DEPTH + 1);

    logic                  inflight_q;
    logic                  inflight_err_q;
    logic [ADDR_WIDTH-1:0] rom_addr_q;

    logic                  accept;
    logic                  good_read;
    logic [CntW:0]         occupancy;
    rom_rsp_t              inflight_rsp;
    rom_rsp_t              head_rsp;
    rom_rsp_t              out_rsp;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CntW-1:0]       fifo_count;
    logic                  unused_signals;

    assign unused_signals = ^{be_i, wdata_i, addr_i[BUS_ADDR_WIDTH-1:ADDR_WIDTH], fifo_full};

    // Request side. The in-flight beat reserves a FIFO slot so the FIFO can never overflow;
    // a same-cycle pop is deliberately not credited, keeping gnt_o off the rready_i path.
    always_comb begin
        occupancy  = {1'b0, fifo_count} + {{CntW{1'b0}}, inflight_q};
        gnt_o      = !rst && (occupancy < (CntW + 1)'(RSP_DEPTH));
        accept     = req_i && gnt_o;
        good_read  = !we_i && is_word_aligned(addr_i[1:0]);
        rom_en_o   = accept && good_read;
        rom_addr_o = rom_en_o ? {addr_i[ADDR_WIDTH-1:2], 2'b00} : rom_addr_q;
    end

    // Response side: the in-flight beat bypasses the FIFO only when nothing is queued ahead.
    always_comb begin
        inflight_rsp.data = inflight_err_q ? '0 : rom_rdata_i;
        inflight_rsp.err  = inflight_err_q;

        rvalid_o = inflight_q || !fifo_empty;
        if (!fifo_empty) begin
            out_rsp = head_rsp;
        end else if (inflight_q) begin
            out_rsp = inflight_rsp;
        end else begin
            out_rsp = '0;
        end
        rdata_o = out_rsp.data;
        rerr_o  = out_rsp.err;

        fifo_pop  = !fifo_empty && rready_i;
        fifo_push = inflight_q && !(fifo_empty && rready_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q     <= 1'b0;
            inflight_err_q <= 1'b0;
            rom_addr_q     <= '0;
        end else begin
            inflight_q     <= accept;
            inflight_err_q <= accept && !good_read;
            if (rom_en_o) begin
                rom_addr_q <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
            end
        end
    end

    boot_rom_rsp_fifo #(
        .Depth(RSP_DEPTH)
    ) u_rsp_fifo (
        .clk_i  (clk),
        .rst_i  (rst),
        .push_i (fifo_push),
        .wdata_i(inflight_rsp),
        .pop_i  (fifo_pop),
        .rdata_o(head_rsp),
        .full_o (fifo_full),
        .empty_o(fifo_empty),
        .count_o(fifo_count)
    );

endmodule

// File: tb/tb_boot_rom_req_adapter.sv
// Bench for boot_rom_req_adapter: directed cycle table, back-to-back and reset sequences,
// then random traffic against a queue-based model of outstanding responses.

module tb_boot_rom_req_adapter;
    import boot_rom_pkg::*;

    localparam int unsigned AW    = 12;
    localparam int unsigned DW    = 32;
    localparam int unsigned BAW   = 32;
    localparam int unsigned DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req = 1'b0;
    logic          gnt;
    logic [BAW-1:0] addr = '0;
    logic          we = 1'b0;
    logic [DW/8-1:0] be = '1;
    logic [DW-1:0] wdata = '0;
    logic          rvalid;
    logic          rready = 1'b1;
    logic [DW-1:0] rdata;
    logic          rerr;
    logic          rom_en;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_rdata = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    boot_rom_req_adapter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .BUS_ADDR_WIDTH(BAW),
        .RSP_DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req),
        .gnt_o      (gnt),
        .addr_i     (addr),
        .we_i       (we),
        .be_i       (be),
        .wdata_i    (wdata),
        .rvalid_o   (rvalid),
        .rready_i   (rready),
        .rdata_o    (rdata),
        .rerr_o     (rerr),
        .rom_en_o   (rom_en),
        .rom_addr_o (rom_addr),
        .rom_rdata_i(rom_rdata)
    );

    function automatic logic [31:0] rom_word(input logic [9:0] idx);
        if (idx == 10'd4) return 32'hDEAD_BEEF;
        return (32'(idx) * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    // ROM macro: one-cycle read latency, garbage on the data pins when not enabled.
    always @(posedge clk) begin
        if (rom_en) rom_rdata <= rom_word(rom_addr[11:2]);
        else        rom_rdata <= $urandom();
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic rr);
        @(posedge clk);
        #1;
        req    = r;
        we     = w;
        addr   = a;
        rready = rr;
        wdata  = $urandom();
        be     = 4'($urandom());
    endtask

    typedef struct {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic        rready;
        logic        gnt;
        logic        en;
        logic [11:0] raddr;
        logic        rvalid;
        logic [31:0] rdata;
        logic        rerr;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic w, input logic [31:0] a,
                                input logic rr, input logic g, input logic e,
                                input logic [11:0] ra, input logic rv,
                                input logic [31:0] rd, input logic re);
        vec_t v;
        v.req = r; v.we = w; v.addr = a; v.rready = rr; v.gnt = g; v.en = e;
        v.raddr = ra; v.rvalid = rv; v.rdata = rd; v.rerr = re;
        return v;
    endfunction

    vec_t     vecs[15];
    rom_rsp_t q[$];

    initial begin
        // Reset state
        @(negedge clk);
        check("reset gnt", gnt, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        check("reset gnt after", gnt, 1'b1);
        check("reset rvalid", rvalid, 1'b0);
        check("reset rdata", rdata, 32'h0);
        check("reset rerr", rerr, 1'b0);
        check("reset rom_en", rom_en, 1'b0);

        // Single read, errors between good reads, then back-pressure with DEPTH=2.
        //            req we addr      rr  gnt en raddr   rv rdata              rerr
        vecs[0]  = mk(1, 0, 32'h10, 1, 1, 1, 12'h010, 0, 32'h0,             0);
        vecs[1]  = mk(1, 1, 32'h04, 1, 1, 0, 12'h010, 1, 32'hDEAD_BEEF,     0);
        vecs[2]  = mk(1, 0, 32'h06, 1, 1, 0, 12'h010, 1, 32'h0,             1);
        vecs[3]  = mk(1, 0, 32'h08, 1, 1, 1, 12'h008, 1, 32'h0,             1);
        vecs[4]  = mk(0, 0, 32'h00, 1, 1, 0, 12'h008, 1, rom_word(10'd2),   0);
        vecs[5]  = mk(0, 0, 32'h00, 1, 1, 0, 12'h008, 0, 32'h0,             0);
        vecs[6]  = mk(1, 0, 32'h20, 0, 1, 1, 12'h020, 0, 32'h0,             0);
        vecs[7]  = mk(1, 0, 32'h24, 0, 1, 1, 12'h024, 1, rom_word(10'd8),   0);
        vecs[8]  = mk(1, 0, 32'h28, 0, 0, 0, 12'h024, 1, rom_word(10'd8),   0);
        vecs[9]  = mk(1, 0, 32'h28, 0, 0, 0, 12'h024, 1, rom_word(10'd8),   0);
        vecs[10] = mk(1, 0, 32'h28, 1, 0, 0, 12'h024, 1, rom_word(10'd8),   0);
        vecs[11] = mk(1, 0, 32'h28, 1, 1, 1, 12'h028, 1, rom_word(10'd9),   0);
        vecs[12] = mk(1, 0, 32'h2C, 1, 1, 1, 12'h02C, 1, rom_word(10'd10),  0);
        vecs[13] = mk(0, 0, 32'h00, 1, 1, 0, 12'h02C, 1, rom_word(10'd11),  0);
        vecs[14] = mk(0, 0, 32'h00, 1, 1, 0, 12'h02C, 0, 32'h0,             0);

        foreach (vecs[i]) begin
            drive(vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].rready);
            @(negedge clk);
            check($sformatf("vec%0d gnt", i), gnt, vecs[i].gnt);
            check($sformatf("vec%0d rom_en", i), rom_en, vecs[i].en);
            check($sformatf("vec%0d rom_addr", i), rom_addr, vecs[i].raddr);
            check($sformatf("vec%0d rvalid", i), rvalid, vecs[i].rvalid);
            check($sformatf("vec%0d rdata", i), rdata, vecs[i].rdata);
            check($sformatf("vec%0d rerr", i), rerr, vecs[i].rerr);
        end

        // Back-to-back: eight reads, one response per cycle, in order.
        for (int i = 0; i <= 8; i++) begin
            drive(i < 8, 1'b0, 32'(i * 4), 1'b1);
            @(negedge clk);
            if (i < 8) begin
                check($sformatf("b2b%0d gnt", i), gnt, 1'b1);
                check($sformatf("b2b%0d rom_en", i), rom_en, 1'b1);
            end
            if (i > 0) begin
                check($sformatf("b2b%0d rvalid", i), rvalid, 1'b1);
                check($sformatf("b2b%0d rdata", i), rdata, rom_word(10'(i - 1)));
                check($sformatf("b2b%0d rerr", i), rerr, 1'b0);
            end
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        check("b2b drained rvalid", rvalid, 1'b0);

        // Reset with two responses outstanding: both must vanish.
        drive(1'b1, 1'b0, 32'h30, 1'b0);
        @(negedge clk);
        check("rstseq gnt0", gnt, 1'b1);
        drive(1'b1, 1'b0, 32'h34, 1'b0);
        @(negedge clk);
        check("rstseq gnt1", gnt, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        check("rstseq queued rvalid", rvalid, 1'b1);
        check("rstseq full gnt", gnt, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("rstseq gnt in reset", gnt, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        check("rstseq rvalid after", rvalid, 1'b0);
        check("rstseq gnt after", gnt, 1'b1);
        drive(1'b1, 1'b0, 32'h0C, 1'b1);
        @(negedge clk);
        check("rstseq fresh rom_en", rom_en, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        check("rstseq fresh rvalid", rvalid, 1'b1);
        check("rstseq fresh rdata", rdata, rom_word(10'd3));
        check("rstseq fresh rerr", rerr, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        check("rstseq no stale", rvalid, 1'b0);

        // Random traffic. Model: q holds every accepted-but-unconsumed response in order.
        q.delete();
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] a;
            logic        exp_gnt;
            logic        exp_en;
            logic        good;
            a = $urandom();
            if ($urandom_range(0, 6) != 0) a[1:0] = 2'b00;
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 6) == 0, a,
                  $urandom_range(0, 2) != 0);
            rst = ($urandom_range(0, 199) == 0);
            @(negedge clk);
            if (rst) begin
                check("rnd gnt in reset", gnt, 1'b0);
                check("rnd rom_en in reset", rom_en, 1'b0);
                q.delete();
            end else begin
                exp_gnt = (q.size() < DEPTH);
                good    = !we && (addr[1:0] == 2'b00);
                exp_en  = req && exp_gnt && good;
                check("rnd gnt", gnt, exp_gnt);
                check("rnd rom_en", rom_en, exp_en);
                if (exp_en) check("rnd rom_addr", rom_addr, {addr[11:2], 2'b00});
                check("rnd rvalid", rvalid, q.size() > 0);
                if (q.size() > 0) begin
                    check("rnd rdata", rdata, q[0].data);
                    check("rnd rerr", rerr, q[0].err);
                    if (rready) void'(q.pop_front());
                end
                if (req && exp_gnt) begin
                    if (good) q.push_back(rom_rsp_t'{data: rom_word(addr[11:2]), err: 1'b0});
                    else      q.push_back(rom_rsp_t'{data: 32'h0, err: 1'b1});
                end
            end
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
